// File: rtl/ram_arbiter.sv
// Two-way arbiter in front of a single-port 8-bit Ram: video tile fetcher (read) vs CPU (read/write).
// Grants are combinational, with at most one Ram access per cycle; read data returns registered one cycle after the grant.
// Requesters hold their request until granted. A pending CPU request that keeps losing to video is forced through after MaxCpuWait cycles.
module ram_arbiter #(
  parameter int Bits       = 16,
  parameter int MaxCpuWait = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vidActive,
  input  logic            vidReq,
  input  logic [Bits-1:0] vidAddr,
  output logic            vidGnt,
  output logic            vidValid,
  output logic [7:0]      vidData,
  input  logic            cpuReq,
  input  logic            cpuWe,
  input  logic [Bits-1:0] cpuAddr,
  input  logic [7:0]      cpuWData,
  output logic            cpuGnt,
  output logic            cpuValid,
  output logic [7:0]      cpuData,
  output logic [Bits-1:0] ramAddr,
  output logic [7:0]      ramWData,
  output logic            ramWe,
  input  logic [7:0]      ramRData
);

  typedef enum logic [1:0] {VPRIO, CPRIO, FORCE} state_t;

  localparam logic [7:0] WaitMax = 8'(MaxCpuWait);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic       vid_gnt, cpu_gnt;

  // State and starvation counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= VPRIO;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Grant selection, starvation counting and next-state decision
  always_comb begin
    vid_gnt    = 1'b0;
    cpu_gnt    = 1'b0;
    wait_next  = '0;
    state_next = vidActive ? VPRIO : CPRIO;

    case (state)
      CPRIO, FORCE: begin
        if (cpuReq)      cpu_gnt = 1'b1;
        else if (vidReq) vid_gnt = 1'b1;
      end
      default: begin
        if (vidReq)      vid_gnt = 1'b1;
        else if (cpuReq) cpu_gnt = 1'b1;
      end
    endcase

    // Nothing is granted while reset is held, so no write or valid pulse can leak out
    if (reset) begin
      vid_gnt = 1'b0;
      cpu_gnt = 1'b0;
    end

    // Count consecutive cycles a CPU request loses; saturate at the limit
    if (cpuReq && !cpu_gnt) begin
      wait_next = (wait_cnt == WaitMax) ? WaitMax : wait_cnt + 8'd1;
    end

    // Reaching the limit forces the CPU through next cycle. FORCE always grants a
    // requesting CPU, which clears the counter, so FORCE lasts a single cycle
    if (wait_next == WaitMax) begin
      state_next = FORCE;
    end
  end

  assign vidGnt   = vid_gnt;
  assign cpuGnt   = cpu_gnt;
  assign ramAddr  = cpu_gnt ? cpuAddr : vidAddr;
  assign ramWData = cpuWData;
  assign ramWe    = cpu_gnt & cpuWe;

  // Registered read return; data registers hold between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vidValid <= 1'b0;
      cpuValid <= 1'b0;
      vidData  <= '0;
      cpuData  <= '0;
    end else begin
      vidValid <= vid_gnt;
      cpuValid <= cpu_gnt & ~cpuWe;
      if (vid_gnt)           vidData <= ramRData;
      if (cpu_gnt && !cpuWe) cpuData <= ramRData;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random traffic.
// A bench-side Ram and a rule-level reference model predict every grant and read return.
// Each cycle is checked mid-period, away from the rising clock edge.
module tb_ram_arbiter;

  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_active = 1'b1, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        vid_gnt, vid_valid, cpu_gnt, cpu_valid, ram_we;
  logic [7:0]  vid_data, cpu_data, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int tests = 0;
  int errs  = 0;

  // Reference model state: consecutive CPU losses, vidActive of the previous cycle,
  // and the expected registered outputs
  int         losses = 0;
  bit         prev_act = 1'b1;
  bit         ev_valid = 1'b0, ec_valid = 1'b0;
  logic [7:0] ev_data = '0, ec_data = '0;
  bit         last_eg_v = 1'b0, last_eg_c = 1'b0;
  bit         dut_vg, dut_cg, dut_we;

  assign ram_rdata = mem[ram_addr];

  always #5 clk = ~clk;

  ram_arbiter #(.Bits(16), .MaxCpuWait(MAX)) dut (
    .clk(clk), .reset(reset), .vidActive(vid_active),
    .vidReq(vid_req), .vidAddr(vid_addr), .vidGnt(vid_gnt),
    .vidValid(vid_valid), .vidData(vid_data),
    .cpuReq(cpu_req), .cpuWe(cpu_we), .cpuAddr(cpu_addr), .cpuWData(cpu_wdata),
    .cpuGnt(cpu_gnt), .cpuValid(cpu_valid), .cpuData(cpu_data),
    .ramAddr(ram_addr), .ramWData(ram_wdata), .ramWe(ram_we), .ramRData(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One arbitration cycle: entered at posedge+1, drives inputs, checks at the
  // falling edge, advances the model, returns at the next posedge+1
  task automatic step(input bit act, input bit vr, input logic [15:0] va,
                      input bit cr, input bit cwe, input logic [15:0] ca,
                      input logic [7:0] cwd);
    bit          cpu_first, eg_v, eg_c, w_en;
    logic [15:0] w_addr;
    logic [7:0]  w_dat;
    vid_active = act; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    #4;
    // CPU goes first when starved long enough or when the previous cycle was blanking
    cpu_first = (cr && losses >= MAX) || !prev_act;
    eg_c = cr && (cpu_first || !vr);
    eg_v = vr && !eg_c;
    chk("vid_gnt",   32'(vid_gnt),   32'(eg_v));
    chk("cpu_gnt",   32'(cpu_gnt),   32'(eg_c));
    chk("ram_we",    32'(ram_we),    32'(eg_c && cwe));
    chk("ram_addr",  32'(ram_addr),  32'(eg_c ? ca : va));
    chk("ram_wdata", 32'(ram_wdata), 32'(cwd));
    chk("vid_valid", 32'(vid_valid), 32'(ev_valid));
    chk("cpu_valid", 32'(cpu_valid), 32'(ec_valid));
    chk("vid_data",  32'(vid_data),  32'(ev_data));
    chk("cpu_data",  32'(cpu_data),  32'(ec_data));
    dut_vg = vid_gnt; dut_cg = cpu_gnt; dut_we = ram_we;
    w_en = ram_we; w_addr = ram_addr; w_dat = ram_wdata;
    ev_valid = eg_v;
    if (eg_v) ev_data = ref_mem[va];
    ec_valid = eg_c && !cwe;
    if (eg_c && !cwe) ec_data = ref_mem[ca];
    if (eg_c && cwe) ref_mem[ca] = cwd;
    if (cr && !eg_c) losses = (losses >= MAX) ? MAX : losses + 1;
    else losses = 0;
    prev_act = act;
    last_eg_v = eg_v; last_eg_c = eg_c;
    @(posedge clk); #1;
    if (w_en) mem[w_addr] = w_dat;
  endtask

  initial begin
    logic [7:0]  b2b [4];
    logic [7:0]  old;
    logic [15:0] va;
    int          cpu_at;
    bit          vr, cr, cwe, act;
    logic [15:0] rva, rca;
    logic [7:0]  rwd;

    b2b[0] = 8'h0E; b2b[1] = 8'h80; b2b[2] = 8'h88; b2b[3] = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h2000] = 8'h0E; mem[16'h2001] = 8'h80; mem[16'h2002] = 8'h88;
    mem[16'h2003] = 8'h00; mem[16'h0003] = 8'h81; mem[16'h0040] = 8'h01;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

    // Reset state, with requests present to show grants are masked
    vid_req = 1'b1; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("rst_vid_gnt",   32'(vid_gnt),   0);
    chk("rst_cpu_gnt",   32'(cpu_gnt),   0);
    chk("rst_ram_we",    32'(ram_we),    0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cpu_valid", 32'(cpu_valid), 0);
    chk("rst_vid_data",  32'(vid_data),  0);
    chk("rst_cpu_data",  32'(cpu_data),  0);
    vid_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Video read alone
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16'h2000, 0, 0, 0, 0);
    chk("vid_alone_gnt",  32'(dut_vg),    1);
    chk("vid_alone_vld",  32'(vid_valid), 1);
    chk("vid_alone_data", 32'(vid_data),  32'h0E);
    chk("vid_alone_cvld", 32'(cpu_valid), 0);

    // Contention in active display: CPU forced through on the 9th cycle
    step(1, 0, 0, 0, 0, 0, 0);
    va = 16'h2000; cpu_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, va, cpu_at < 0, 0, 16'h0003, 0);
      if (dut_vg) va++;
      if (dut_cg) begin
        cpu_at = i;
        chk("force_data", 32'(cpu_data), 32'h81);
      end
    end
    chk("force_slot", 32'(cpu_at), 32'd8);
    chk("force_vid_resume", 32'(dut_vg), 1);

    // Blanking priority and delayed priority switch
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h2000, 1, 0, 16'h0003, 0);
    chk("blank_cpu_first", 32'(dut_cg), 1);
    step(0, 1, 16'h2000, 1, 0, 16'h0004, 0);
    chk("blank_cpu_again", 32'(dut_cg), 1);
    step(0, 1, 16'h2000, 0, 0, 0, 0);
    chk("blank_vid_after", 32'(dut_vg), 1);
    step(1, 1, 16'h2001, 1, 0, 16'h0005, 0);
    chk("switch_lag_cpu", 32'(dut_cg), 1);
    step(1, 1, 16'h2001, 1, 0, 16'h0005, 0);
    chk("switch_vid_prio", 32'(dut_vg), 1);
    step(1, 0, 0, 1, 0, 16'h0005, 0);

    // CPU write then read-back
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 16'h0040, 8'h5A);
    chk("wr_we",   32'(dut_we),    1);
    chk("wr_cvld", 32'(cpu_valid), 0);
    step(1, 0, 0, 1, 0, 16'h0040, 0);
    chk("rb_we",   32'(dut_we),    0);
    chk("rb_vld",  32'(cpu_valid), 1);
    chk("rb_data", 32'(cpu_data),  32'h5A);

    // Back-to-back video stream
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 16'h2000 + 16'(i), 0, 0, 0, 0);
      chk("b2b_gnt",  32'(dut_vg),   1);
      chk("b2b_data", 32'(vid_data), 32'(b2b[i]));
    end

    // Random traffic; requests are held until the model says they were granted
    vr = 0; cr = 0; cwe = 0; act = 1; rva = '0; rca = '0; rwd = '0;
    for (int i = 0; i < 800; i++) begin
      if (!vr || last_eg_v) begin
        vr  = ($urandom % 8) != 0;
        rva = 16'($urandom % 32);
      end
      if (!cr || last_eg_c) begin
        cr  = ($urandom % 2) != 0;
        cwe = ($urandom % 3) == 0;
        rca = 16'($urandom % 32);
        rwd = 8'($urandom);
      end
      if (($urandom % 16) == 0) act = !act;
      step(act, vr, rva, cr, cwe, rca, rwd);
    end
    step(1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a CPU write grant
    step(1, 1, 16'h2000, 0, 0, 0, 0);
    old = mem[16'h0100];
    vid_active = 1; vid_req = 0; cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0100; cpu_wdata = ~old;
    #2;
    chk("mid_pre_gnt", 32'(cpu_gnt), 1);
    chk("mid_pre_we",  32'(ram_we),  1);
    reset = 1'b1;
    #1;
    chk("mid_cpu_gnt",   32'(cpu_gnt),   0);
    chk("mid_vid_gnt",   32'(vid_gnt),   0);
    chk("mid_ram_we",    32'(ram_we),    0);
    chk("mid_vid_valid", 32'(vid_valid), 0);
    chk("mid_vid_data",  32'(vid_data),  0);
    chk("mid_cpu_data",  32'(cpu_data),  0);
    @(posedge clk); #1;
    chk("mid_mem_kept", 32'(mem[16'h0100]), 32'(old));
    chk("mid_cpu_valid", 32'(cpu_valid), 0);
    cpu_req = 1'b0;
    reset = 1'b0;
    losses = 0; prev_act = 1'b1;
    ev_valid = 1'b0; ec_valid = 1'b0; ev_data = '0; ec_data = '0;
    // Video-priority state after release even though blanking is signalled
    step(0, 1, 16'h2000, 1, 0, 16'h0003, 0);
    chk("post_rst_vprio", 32'(dut_vg), 1);
    step(0, 1, 16'h2001, 1, 0, 16'h0003, 0);
    chk("post_rst_cprio", 32'(dut_cg), 1);
    // Starvation counter restarts from zero after reset
    step(1, 0, 0, 0, 0, 0, 0);
    cpu_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 16'h2000, cpu_at < 0, 0, 16'h0003, 0);
      if (dut_cg && cpu_at < 0) cpu_at = i;
    end
    chk("post_rst_force", 32'(cpu_at), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8-bit Ram between two requesters: the video tile fetcher (read-only; tilemap entries at 0x0000, 4bpp patterns at 0x2000) and the CPU (read/write).
- Sits directly in front of the Ram and drives its address, dataIn and writeEnabled. Ram read data is combinational.
- Video has priority during active display and the CPU has priority during blanking. A starvation counter guarantees the CPU a slot during long video runs.
- Read data is registered and returned one cycle after the grant.

Parameters:
- Bits, 16, Ram address width; must match the Ram instance.
- MaxCpuWait, 8, maximum consecutive cycles a pending CPU request may lose to video before it is forced through (1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- vidActive  input  1  high during active display (video priority); low during blanking (CPU priority).
- vidReq  input  1  video read request; held with vidAddr until vidGnt.
- vidAddr  input  Bits  video read address.
- vidGnt  output  1  combinational; the video access occurs this cycle.
- vidValid  output  1  registered; one-cycle pulse, vidData valid.
- vidData  output  8  registered video read data.
- cpuReq  input  1  CPU request; held with cpuWe/cpuAddr/cpuWData until cpuGnt.
- cpuWe  input  1  1 = write, 0 = read.
- cpuAddr  input  Bits  CPU address.
- cpuWData  input  8  CPU write data.
- cpuGnt  output  1  combinational; the CPU access occurs this cycle.
- cpuValid  output  1  registered; one-cycle pulse after a granted CPU read only.
- cpuData  output  8  registered CPU read data.
- ramAddr  output  Bits  to Ram address.
- ramWData  output  8  to Ram dataIn.
- ramWe  output  1  to Ram writeEnabled.
- ramRData  input  8  from Ram dataOut.

Behaviour:
- Reset (asynchronous) clears vidValid, cpuValid, vidData, cpuData and waitCnt; state = VPRIO. While reset is high, vidGnt, cpuGnt and ramWe are forced to 0.
- One Ram access per cycle at most. vidGnt and cpuGnt are mutually exclusive, and each is asserted only when its request is high.
- State machine, evaluated every cycle:
  - VPRIO (vidActive=1): grant video if vidReq, else CPU if cpuReq.
  - CPRIO (vidActive=0): grant CPU if cpuReq, else video if vidReq.
  - FORCE: grant CPU if cpuReq (video waits), else video.
- Transitions:
  - Next state is FORCE when waitCnt reaches MaxCpuWait.
  - Otherwise the next state follows vidActive of the current cycle.
  - FORCE exits after exactly one cycle, or immediately if cpuReq drops.
  - A vidActive change takes effect the cycle after it is sampled.
- waitCnt:
  - Increments (saturating at MaxCpuWait) on each cycle with cpuReq=1 and cpuGnt=0.
  - Clears on cpuGnt or when cpuReq=0.
- Ram drive:
  - ramAddr = granted requester's address; with no grant, ramAddr = vidAddr.
  - ramWData = cpuWData.
  - ramWe = cpuGnt & cpuWe; the Ram writes on that rising edge.
- Read return:
  - Next edge after vidGnt: vidData <= ramRData, vidValid <= 1.
  - Next edge after cpuGnt with cpuWe=0: cpuData <= ramRData, cpuValid <= 1.
  - Valid flags are 0 on all other cycles.
  - Data registers hold their last value when not updated.
- Back-to-back: a requester may change its address on the edge ending its grant cycle and be granted again the next cycle. Throughput is 1 access/cycle for a single requester.
- Write then read of the same address in consecutive CPU grants returns the new data.
- Reset mid-access: a grant in the reset cycle is discarded, with no write and no valid pulse. Requesters must re-present their requests after reset.

Test Plan:
- Video read alone: vidActive=1, vidReq=1, vidAddr=0x2000 (initial 0x0E) → vidGnt the same cycle; vidValid=1 and vidData=0x0E the next cycle; cpuValid stays 0.
- Contention in active display: vidActive=1, both requesting, cpuAddr=0x0003 (0x81), video walking 0x2000.. → video granted for 8 cycles, CPU forced on the 9th cycle, cpuData=0x81 on the 10th, video resumes on the 10th.
- Blanking priority: vidActive=0, both requesting → cpuGnt the first cycle; vidGnt only once cpuReq drops; the 0→1 vidActive switch changes priority one cycle later.
- CPU write/read-back: write 0x5A to 0x0040 (initial 0x01) → ramWe=1 for exactly one cycle and cpuValid=0; a following read of 0x0040 returns 0x5A.
- Back-to-back video: video streams 0x2000–0x2003 with no CPU → 4 consecutive grants; vidData=0x0E,0x80,0x88,0x00 on the following 4 cycles.
- Async reset: assert reset between clock edges during a CPU write grant → grants and ramWe drop immediately, valids/waitCnt clear, memory unchanged, state=VPRIO after release.
